// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Bus-side memory access sequencer for the LC-3 datapath. Holds MAR and
//   MDR and runs one SRAM read or write per accepted request. The access
//   phase is stretched by WAIT_CYCLES extra cycles to meet slow SRAM timing.
//
//   Sequence: IDLE -> SETUP (1) -> ACCESS (WAIT_CYCLES+1) -> DONE (1) -> IDLE
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   req, we               request / write select, sampled only in IDLE
//   addr_in, data_in      address into MAR, write data into MDR (writes only)
//   busy, done            not-idle flag, one-cycle completion pulse
//   data_out              MDR contents (read result, gated onto BUS)
//   mem_addr, mem_wdata   MAR / MDR driven to the SRAM
//   mem_rdata             SRAM read data
//   mem_ce_n/oe_n/we_n    active-low SRAM strobes
module mem_access_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req,
    input  logic          we,
    input  logic [AW-1:0] addr_in,
    input  logic [DW-1:0] data_in,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] data_out,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_ce_n,
    output logic          mem_oe_n,
    output logic          mem_we_n
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    logic [1:0]    state;
    logic          op_wr;     // latched we for the access in flight
    logic [3:0]    wait_cnt;
    logic [AW-1:0] mar;
    logic [DW-1:0] mdr;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            op_wr    <= 1'b0;
            wait_cnt <= 4'd0;
            mar      <= '0;
            mdr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        mar   <= addr_in;
                        op_wr <= we;
                        // Reads leave MDR alone until the data actually returns.
                        if (we) mdr <= data_in;
                        state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wait_cnt <= WAIT_LD;
                    state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        if (!op_wr) mdr <= mem_rdata;
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes decode from registered state only, so they are glitch-free
    // and mem_addr (MAR) is already stable one cycle before mem_we_n falls
    // and one cycle after it rises.
    always_comb begin
        mem_ce_n = 1'b1;
        mem_oe_n = 1'b1;
        mem_we_n = 1'b1;
        case (state)
            S_SETUP: begin
                mem_ce_n = 1'b0;
                mem_oe_n = op_wr;
            end
            S_ACCESS: begin
                mem_ce_n = 1'b0;
                mem_oe_n = op_wr;
                mem_we_n = !op_wr;
            end
            default: ;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign data_out  = mdr;
    assign mem_addr  = mar;
    assign mem_wdata = mdr;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    // DUT A: WAIT_CYCLES=2
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [15:0] a_addr_in = '0, a_data_in = '0;
    logic        a_busy, a_done, a_ce_n, a_oe_n, a_we_n;
    logic [15:0] a_data_out, a_mem_addr, a_mem_wdata, a_mem_rdata;

    // DUT B: WAIT_CYCLES=0
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [15:0] b_addr_in = '0, b_data_in = '0;
    logic        b_busy, b_done, b_ce_n, b_oe_n, b_we_n;
    logic [15:0] b_data_out, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_access_ctrl #(.WAIT_CYCLES(2), .AW(16), .DW(16)) u_a (
        .Clk(Clk), .Reset(Reset), .req(a_req), .we(a_we),
        .addr_in(a_addr_in), .data_in(a_data_in),
        .busy(a_busy), .done(a_done), .data_out(a_data_out),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .mem_ce_n(a_ce_n), .mem_oe_n(a_oe_n), .mem_we_n(a_we_n)
    );

    mem_access_ctrl #(.WAIT_CYCLES(0), .AW(16), .DW(16)) u_b (
        .Clk(Clk), .Reset(Reset), .req(b_req), .we(b_we),
        .addr_in(b_addr_in), .data_in(b_data_in),
        .busy(b_busy), .done(b_done), .data_out(b_data_out),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .mem_ce_n(b_ce_n), .mem_oe_n(b_oe_n), .mem_we_n(b_we_n)
    );

    // SRAM models: async read while ce/oe low, write on edge while ce/we low
    logic [15:0] mem_a [0:65535];
    logic [15:0] mem_b [0:65535];
    assign a_mem_rdata = (!a_ce_n && !a_oe_n) ? mem_a[a_mem_addr] : 16'h0000;
    assign b_mem_rdata = (!b_ce_n && !b_oe_n) ? mem_b[b_mem_addr] : 16'h0000;
    always @(posedge Clk) if (!a_ce_n && !a_we_n) mem_a[a_mem_addr] <= a_mem_wdata;
    always @(posedge Clk) if (!b_ce_n && !b_we_n) mem_b[b_mem_addr] <= b_mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Per-cycle history of DUT A; index i = cycle following edge i (edge 0 = accept)
    logic        busy_h [32];
    logic        done_h [32];
    logic        oe_h   [32];
    logic        we_h   [32];
    logic [15:0] addr_h [32];
    logic [15:0] wd_h   [32];
    logic [15:0] dout_h [32];
    int c_busy, c_done, c_oe, c_we, done_at, addr_bad, wd_bad;

    task automatic start_a(input logic w, input logic [15:0] a, input logic [15:0] d);
        a_req = 1'b1; a_we = w; a_addr_in = a; a_data_in = d;
        step();
    endtask

    task automatic watch(input int n, input int drop_at);
        for (int i = 0; i < n; i++) begin
            busy_h[i] = a_busy;  done_h[i] = a_done;
            oe_h[i]   = a_oe_n;  we_h[i]   = a_we_n;
            addr_h[i] = a_mem_addr; wd_h[i] = a_mem_wdata; dout_h[i] = a_data_out;
            if (i == drop_at) a_req = 1'b0;
            step();
        end
    endtask

    task automatic tally(input int n, input logic [15:0] ea, input logic [15:0] ewd);
        c_busy = 0; c_done = 0; c_oe = 0; c_we = 0; done_at = -1; addr_bad = 0; wd_bad = 0;
        for (int i = 0; i < n; i++) begin
            if (busy_h[i]) c_busy++;
            if (!oe_h[i]) c_oe++;
            if (!we_h[i]) c_we++;
            if (done_h[i]) begin
                c_done++;
                if (done_at < 0) done_at = i;
            end
            if (busy_h[i] && addr_h[i] != ea) addr_bad++;
            if (busy_h[i] && wd_h[i] != ewd) wd_bad++;
        end
    endtask

    initial begin
        mem_a[16'h3000] = 16'h1234;
        mem_a[16'h6001] = 16'h0001;
        mem_a[16'h0010] = 16'h00AA;
        mem_a[16'h0020] = 16'h00BB;
        mem_b[16'h0100] = 16'h5A5A;

        // Reset state
        Reset = 1'b1;
        step(); step();
        chk("rst_busy",   32'(a_busy), 32'd0);
        chk("rst_done",   32'(a_done), 32'd0);
        chk("rst_strobe", 32'({a_ce_n, a_oe_n, a_we_n}), 32'b111);
        chk("rst_dout",   32'(a_data_out), 32'h0);
        chk("rst_addr",   32'(a_mem_addr), 32'h0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        Reset = 1'b0;
        step();

        // Read x3000, WAIT_CYCLES=2
        start_a(1'b0, 16'h3000, 16'h0);
        watch(8, 0);
        tally(8, 16'h3000, 16'h0);
        chk("rd_busy_rise", 32'(busy_h[0]), 32'd1);
        chk("rd_busy_cnt",  32'(c_busy), 32'd5);
        chk("rd_oe_cnt",    32'(c_oe), 32'd4);
        chk("rd_we_cnt",    32'(c_we), 32'd0);
        chk("rd_done_cnt",  32'(c_done), 32'd1);
        chk("rd_done_at",   32'(done_at), 32'd4);
        chk("rd_addr_stab", 32'(addr_bad), 32'd0);
        chk("rd_dout_pre",  32'(dout_h[3]), 32'h0);
        chk("rd_dout_done", 32'(dout_h[4]), 32'h1234);
        chk("rd_dout_end",  32'(a_data_out), 32'h1234);

        // Write xBEEF to x4005, then read it back
        start_a(1'b1, 16'h4005, 16'hBEEF);
        watch(8, 0);
        tally(8, 16'h4005, 16'hBEEF);
        chk("wr_we_cnt",    32'(c_we), 32'd3);
        chk("wr_oe_cnt",    32'(c_oe), 32'd0);
        chk("wr_we_setup",  32'(we_h[0]), 32'd1);
        chk("wr_we_hold",   32'(we_h[4]), 32'd1);
        chk("wr_addr_stab", 32'(addr_bad), 32'd0);
        chk("wr_wd_stab",   32'(wd_bad), 32'd0);
        chk("wr_done_cnt",  32'(c_done), 32'd1);
        chk("wr_mem",       32'(mem_a[16'h4005]), 32'hBEEF);
        start_a(1'b0, 16'h4005, 16'h0);
        watch(8, 0);
        chk("wr_readback",  32'(a_data_out), 32'hBEEF);

        // Read keeps old MDR until completion
        start_a(1'b1, 16'h6000, 16'h7777);
        watch(6, 0);
        start_a(1'b0, 16'h6001, 16'h0);
        watch(8, 0);
        chk("hold_dout_s",  32'(dout_h[0]), 32'h7777);
        chk("hold_dout_a",  32'(dout_h[3]), 32'h7777);
        chk("hold_dout_d",  32'(dout_h[4]), 32'h0001);

        // Request held high while busy
        start_a(1'b0, 16'h0010, 16'h0);
        a_addr_in = 16'h0020;
        watch(14, 6);
        tally(14, 16'h0010, 16'h0);
        chk("bb_dout_1",    32'(dout_h[4]), 32'h00AA);
        chk("bb_addr_1",    32'(addr_h[4]), 32'h0010);
        chk("bb_idle_gap",  32'(busy_h[5]), 32'd0);
        chk("bb_busy_2",    32'(busy_h[6]), 32'd1);
        chk("bb_addr_2",    32'(addr_h[6]), 32'h0020);
        chk("bb_done_cnt",  32'(c_done), 32'd2);
        chk("bb_done_2",    32'(done_h[10]), 32'd1);
        chk("bb_dout_2",    32'(a_data_out), 32'h00BB);

        // Reset during second ACCESS cycle of a write
        start_a(1'b1, 16'h5000, 16'h1111);
        a_req = 1'b0;
        step();            // first ACCESS
        step();            // second ACCESS
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mr_busy",   32'(a_busy), 32'd0);
        chk("mr_done",   32'(a_done), 32'd0);
        chk("mr_strobe", 32'({a_ce_n, a_oe_n, a_we_n}), 32'b111);
        chk("mr_dout",   32'(a_data_out), 32'h0);
        chk("mr_addr",   32'(a_mem_addr), 32'h0);
        watch(4, -1);
        tally(4, 16'h0, 16'h0);
        chk("mr_no_done", 32'(c_done), 32'd0);
        start_a(1'b0, 16'h3000, 16'h0);
        watch(8, 0);
        tally(8, 16'h3000, 16'h0);
        chk("mr_rd_done_at", 32'(done_at), 32'd4);
        chk("mr_rd_dout",    32'(a_data_out), 32'h1234);

        // WAIT_CYCLES=0 build
        begin
            int bb, bd, bat;
            bb = 0; bd = 0; bat = -1;
            b_req = 1'b1; b_we = 1'b0; b_addr_in = 16'h0100;
            step();
            for (int i = 0; i < 6; i++) begin
                if (b_busy) bb++;
                if (b_done) begin
                    bd++;
                    if (bat < 0) bat = i;
                end
                if (i == 0) b_req = 1'b0;
                step();
            end
            chk("w0_busy_cnt", 32'(bb), 32'd3);
            chk("w0_done_cnt", 32'(bd), 32'd1);
            chk("w0_done_at",  32'(bat), 32'd2);
            chk("w0_dout",     32'(b_data_out), 32'h5A5A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
